noc_test_node: RTL and testbench
================================

# noc_test_node

Traffic-generator and sink endpoint for the local port of one mesh router in `Noc_connector`. After reset it injects a fixed number of fixed-length packets addressed to a parameterised destination node. It also accepts every flit the router delivers, and counts complete packets addressed to itself. Four instances, one per node of the 2×2 mesh, form the fabric self-test.

## Interface
Parameters:
- `X_ID`, default 0: own mesh X coordinate.
- `Y_ID`, default 0: own mesh Y coordinate.
- `DEST_X_ID`, default 1: destination X coordinate for generated packets.
- `DEST_Y_ID`, default 1: destination Y coordinate for generated packets.
- `DATA_WIDTH`, default `Noc_Data_Width` (32): flit width.
- `PKT_LEN`, default 4: flits per packet, header and tail included; must be ≥2.
- `NUM_PKTS`, default 16: packets to send.
- `START_DELAY`, default 4: idle cycles after reset before the first header.
- `GAP`, default 8: idle cycles between a tail and the next header.

Ports (clock and reset first). One clock; reset is synchronous and active-high:
- `noc_clk`, in, 1: clock.
- `noc_rst_n`, in, 1: synchronous, active-high reset. Asserting 1 resets the block on the next rising edge.
- `receive_valid`, in, 1: router-to-node flit valid.
- `receive_ready`, out, 1: node can accept a flit.
- `receive_flit`, in, DATA_WIDTH: incoming flit.
- `receive_is_header`, in, 1: incoming flit is a header.
- `receive_is_tail`, in, 1: incoming flit is a tail.
- `sender_valid`, out, 1: node-to-router flit valid.
- `sender_ready`, in, 1: router accepts the flit.
- `sender_flit`, out, DATA_WIDTH: outgoing flit.
- `sender_is_header`, out, 1: outgoing flit is a header.
- `sender_is_tail`, out, 1: outgoing flit is a tail.
- `receive_num`, out, 8: count of complete packets received that were addressed to this node.

## Operation
- **Handshake.** A transfer occurs on a rising edge where valid=1 and ready=1 on that channel.
- **Header flit layout.** Bits not listed are 0.
  - [3:0] dest Y
  - [7:4] dest X
  - [11:8] src Y
  - [15:12] src X
  - [23:16] packet sequence number, starting at 0
- **Body and tail flit layout.** [23:16] sequence number, [7:0] flit index (1..PKT_LEN-1); all other bits 0.
- **Sender state machine.**
  - States are WAIT, SEND, DONE.
  - WAIT counts down START_DELAY on the first entry, and GAP on later entries. On expiry it goes to SEND with flit index 0.
  - SEND drives the current flit. On each transfer the index advances.
  - When the transfer carries index PKT_LEN-1 (the tail):
    - the sequence number increments;
    - the block goes to WAIT if packets remain, otherwise to DONE.
  - DONE holds `sender_valid`=0 permanently, until reset.
- **Output flags.** `sender_is_header`=1 only at index 0. `sender_is_tail`=1 only at index PKT_LEN-1. Both flags are 0 whenever `sender_valid`=0.
- **Receiver.**
  - `receive_ready`=1 in every cycle after reset.
  - An accepted header latches `match`, which is set when header[7:4]==X_ID and header[3:0]==Y_ID.
  - An accepted tail with `match`=1 increments `receive_num`. `receive_num` saturates at 255.
  - Packets with `match`=0 are silently discarded and not counted.
  - A flit flagged as both header and tail is handled header-first. Its match result applies to its own tail, so it counts immediately if matched.

## Timing
- **Reset values.** `sender_valid`=0, `sender_flit`=0, both sender flags 0, `receive_ready`=0, `receive_num`=0. The state machine enters WAIT with the START_DELAY count loaded.
- **First header.** `sender_valid` rises exactly START_DELAY+1 cycles after the first edge with reset deasserted.
- **Register outputs.** All outputs come straight from registers; there is no combinational path from any input to any output.
- **Stall rule.** While `sender_valid`=1 and `sender_ready`=0, `sender_flit` and both flags hold stable.
- **Back-to-back flits.** Flits within a packet go back-to-back, one per cycle, while `sender_ready`=1.
- **Inter-packet gap.** Exactly GAP cycles with valid=0 follow the tail transfer.
- **Counter update.** `receive_num` updates the cycle after the tail transfer.
- **Reset mid-packet.** Aborts the packet: valid drops, the sequence number clears, and the start delay restarts. No partial-packet recovery is performed.

## Structure
- **Shared package** (alongside `Noc_parameters`):
  - `Noc_Data_Width`
  - header field offsets and widths (dest X/Y, src X/Y, sequence number)
  - a header-pack function
- **Sub-module.** `noc_test_sink` is the natural sub-module: the receive handshake, the `match` latch, and the saturating counter. The sender FSM stays in the top.

## Test plan
- **Single node, default parameters, `sender_ready` tied 1.** First header at cycle 5 after reset; for node (0,0) sending to (1,1), header = 0x00000011. Four flits per packet; tail flit = 0x00000003. 16 packets total, 8-cycle gaps, then valid stays 0.
- **Backpressure.** Hold `sender_ready`=0 for 3 cycles mid-packet. The flit and flags stay stable; no index is skipped or duplicated.
- **Receive matching.** Inject a 4-flit packet with header dest (0,0) into node (0,0): `receive_num` 0→1. Inject one with dest (1,0): count unchanged.
- **Single-flit packet.** Header=tail=1 and addressed to the node → count +1.
- **Saturation.** Deliver 260 matching packets → `receive_num`=255.
- **Mesh integration.** Four nodes on `Noc_connector`, in cross-diagonal pairs (0,0)↔(1,1) and (1,0)↔(0,1). After draining, every node's `receive_num`=16. Reset asserted mid-run → all outputs are at their reset values the next cycle.

Source files
------------

// File: rtl/noc_test_node_pkg.sv
// Shared definitions for the NoC self-test endpoint: flit width, header field
// layout, sender FSM state encoding and flit pack helpers.
package noc_test_node_pkg;

    localparam int unsigned Noc_Data_Width = 32;

    // Header / body field offsets and widths
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned DEST_Y_LSB = 0;
    localparam int unsigned DEST_X_LSB = 4;
    localparam int unsigned SRC_Y_LSB  = 8;
    localparam int unsigned SRC_X_LSB  = 12;
    localparam int unsigned SEQ_LSB    = 16;
    localparam int unsigned SEQ_W      = 8;
    localparam int unsigned IDX_LSB    = 0;
    localparam int unsigned FIDX_W     = 8;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } send_state_e;

    // Header flit payload, MSB first
    typedef struct packed {
        logic [7:0]         rsvd;
        logic [SEQ_W-1:0]   seq;
        logic [COORD_W-1:0] src_x;
        logic [COORD_W-1:0] src_y;
        logic [COORD_W-1:0] dest_x;
        logic [COORD_W-1:0] dest_y;
    } noc_header_t;

    // Body / tail flit payload, MSB first
    typedef struct packed {
        logic [7:0]        rsvd_hi;
        logic [SEQ_W-1:0]  seq;
        logic [7:0]        rsvd_lo;
        logic [FIDX_W-1:0] idx;
    } noc_body_t;

    function automatic logic [Noc_Data_Width-1:0] pack_header(
        input logic [COORD_W-1:0] dest_x,
        input logic [COORD_W-1:0] dest_y,
        input logic [COORD_W-1:0] src_x,
        input logic [COORD_W-1:0] src_y,
        input logic [SEQ_W-1:0]   seq
    );
        noc_header_t h;
        h        = '0;
        h.dest_x = dest_x;
        h.dest_y = dest_y;
        h.src_x  = src_x;
        h.src_y  = src_y;
        h.seq    = seq;
        return h;
    endfunction

    function automatic logic [Noc_Data_Width-1:0] pack_body(
        input logic [SEQ_W-1:0]  seq,
        input logic [FIDX_W-1:0] idx
    );
        noc_body_t b;
        b     = '0;
        b.seq = seq;
        b.idx = idx;
        return b;
    endfunction

endpackage

// File: rtl/noc_test_node_sink.sv
// Receive side of the test node: always-ready flit sink that latches the
// destination match on each header and counts matched tails (saturating).
// Ports: noc_clk/noc_rst_n (sync, active-high); receive_* handshake from the
// router; receive_num = matched packets received.
module noc_test_node_sink
    import noc_test_node_pkg::*;
#(
    parameter int unsigned X_ID       = 0,
    parameter int unsigned Y_ID       = 0,
    parameter int unsigned DATA_WIDTH = Noc_Data_Width
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  receive_valid,
    output logic                  receive_ready,
    input  logic [DATA_WIDTH-1:0] receive_flit,
    input  logic                  receive_is_header,
    input  logic                  receive_is_tail,
    output logic [7:0]            receive_num
);

    logic xfer_c;
    logic hdr_match_c;
    logic pkt_match_c;
    logic match_q;
    logic unused_flit_bits;

    assign xfer_c      = receive_valid & receive_ready;
    assign hdr_match_c = (receive_flit[DEST_X_LSB +: COORD_W] == COORD_W'(X_ID)) &&
                         (receive_flit[DEST_Y_LSB +: COORD_W] == COORD_W'(Y_ID));
    // A single-flit packet uses its own header's match result
    assign pkt_match_c = receive_is_header ? hdr_match_c : match_q;

    // Only the destination fields matter to the sink
    assign unused_flit_bits = ^receive_flit[DATA_WIDTH-1:DEST_X_LSB+COORD_W];

    // Handshake, match latch and saturating packet counter
    always_ff @(posedge noc_clk) begin
        if (noc_rst_n) begin
            receive_ready <= 1'b0;
            match_q       <= 1'b0;
            receive_num   <= 8'd0;
        end else begin
            receive_ready <= 1'b1;
            if (xfer_c && receive_is_header) begin
                match_q <= hdr_match_c;
            end
            if (xfer_c && receive_is_tail && pkt_match_c && (receive_num != 8'hFF)) begin
                receive_num <= receive_num + 8'd1;
            end
        end
    end

endmodule

// File: rtl/noc_test_node.sv
// NoC self-test endpoint: after reset injects NUM_PKTS packets of PKT_LEN
// flits to (DEST_X_ID, DEST_Y_ID), and sinks/counts packets addressed to
// (X_ID, Y_ID).
// Ports: noc_clk/noc_rst_n (sync, active-high); receive_* router->node
// channel; sender_* node->router channel; receive_num matched-packet count.
// All outputs are registered.
module noc_test_node
    import noc_test_node_pkg::*;
#(
    parameter int unsigned X_ID        = 0,
    parameter int unsigned Y_ID        = 0,
    parameter int unsigned DEST_X_ID   = 1,
    parameter int unsigned DEST_Y_ID   = 1,
    parameter int unsigned DATA_WIDTH  = Noc_Data_Width,
    parameter int unsigned PKT_LEN     = 4,
    parameter int unsigned NUM_PKTS    = 16,
    parameter int unsigned START_DELAY = 4,
    parameter int unsigned GAP         = 8
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  receive_valid,
    output logic                  receive_ready,
    input  logic [DATA_WIDTH-1:0] receive_flit,
    input  logic                  receive_is_header,
    input  logic                  receive_is_tail,
    output logic                  sender_valid,
    input  logic                  sender_ready,
    output logic [DATA_WIDTH-1:0] sender_flit,
    output logic                  sender_is_header,
    output logic                  sender_is_tail,
    output logic [7:0]            receive_num
);

    localparam int unsigned CNT_MAX  = (START_DELAY > GAP) ? START_DELAY : GAP;
    localparam int unsigned CNT_W    = (CNT_MAX == 0) ? 1 : $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W    = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PKT_LEN - 1);
    localparam logic [SEQ_W-1:0] LAST_SEQ   = SEQ_W'(NUM_PKTS - 1);
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_DELAY);
    // The gap count is loaded on the tail edge itself, which is already the
    // first idle cycle, hence one less than GAP.
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP == 0) ? 0 : GAP - 1);

    send_state_e           state_q, state_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [IDX_W-1:0]      idx_q, idx_n;
    logic [SEQ_W-1:0]      seq_q, seq_n;
    logic                  valid_n;
    logic [DATA_WIDTH-1:0] flit_n;
    logic                  hdr_n;
    logic                  tail_n;

    // Flit contents for a given sequence number and in-packet index
    function automatic logic [DATA_WIDTH-1:0] flit_for(
        input logic [SEQ_W-1:0] seq,
        input logic [IDX_W-1:0] idx
    );
        if (idx == '0) begin
            return DATA_WIDTH'(pack_header(COORD_W'(DEST_X_ID), COORD_W'(DEST_Y_ID),
                                           COORD_W'(X_ID), COORD_W'(Y_ID), seq));
        end
        return DATA_WIDTH'(pack_body(seq, FIDX_W'(idx)));
    endfunction

    // Sender state and registered outputs
    always_ff @(posedge noc_clk) begin
        if (noc_rst_n) begin
            state_q          <= ST_WAIT;
            cnt_q            <= START_LOAD;
            idx_q            <= '0;
            seq_q            <= '0;
            sender_valid     <= 1'b0;
            sender_flit      <= '0;
            sender_is_header <= 1'b0;
            sender_is_tail   <= 1'b0;
        end else begin
            state_q          <= state_n;
            cnt_q            <= cnt_n;
            idx_q            <= idx_n;
            seq_q            <= seq_n;
            sender_valid     <= valid_n;
            sender_flit      <= flit_n;
            sender_is_header <= hdr_n;
            sender_is_tail   <= tail_n;
        end
    end

    // Next state and next output values
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        seq_n   = seq_q;
        valid_n = sender_valid;
        flit_n  = sender_flit;
        hdr_n   = sender_is_header;
        tail_n  = sender_is_tail;

        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_n = ST_SEND;
                    idx_n   = '0;
                    valid_n = 1'b1;
                    flit_n  = flit_for(seq_q, '0);
                    hdr_n   = 1'b1;
                    tail_n  = 1'b0;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (sender_valid && sender_ready) begin
                    if (idx_q == LAST_IDX) begin
                        seq_n   = seq_q + SEQ_W'(1);
                        valid_n = 1'b0;
                        flit_n  = '0;
                        hdr_n   = 1'b0;
                        tail_n  = 1'b0;
                        if (seq_q == LAST_SEQ) begin
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_WAIT;
                            cnt_n   = GAP_LOAD;
                        end
                    end else begin
                        idx_n  = idx_q + IDX_W'(1);
                        flit_n = flit_for(seq_q, idx_q + IDX_W'(1));
                        hdr_n  = 1'b0;
                        tail_n = ((idx_q + IDX_W'(1)) == LAST_IDX);
                    end
                end
            end
            ST_DONE: begin
                valid_n = 1'b0;
                hdr_n   = 1'b0;
                tail_n  = 1'b0;
            end
            default: begin
                state_n = ST_DONE;
                valid_n = 1'b0;
                hdr_n   = 1'b0;
                tail_n  = 1'b0;
            end
        endcase
    end

    noc_test_node_sink #(
        .X_ID       (X_ID),
        .Y_ID       (Y_ID),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sink (
        .noc_clk           (noc_clk),
        .noc_rst_n         (noc_rst_n),
        .receive_valid     (receive_valid),
        .receive_ready     (receive_ready),
        .receive_flit      (receive_flit),
        .receive_is_header (receive_is_header),
        .receive_is_tail   (receive_is_tail),
        .receive_num       (receive_num)
    );

endmodule

// File: tb/tb_noc_test_node.sv
// Bench for noc_test_node at default parameters, node (0,0) sending to (1,1).
module tb_noc_test_node;

    localparam int unsigned DW          = 32;
    localparam int unsigned PKT_LEN     = 4;
    localparam int unsigned NUM_PKTS    = 16;
    localparam int unsigned START_DELAY = 4;
    localparam int unsigned GAP         = 8;
    localparam int unsigned MY_X        = 0;
    localparam int unsigned MY_Y        = 0;
    localparam int unsigned DX          = 1;
    localparam int unsigned DY          = 1;

    logic          noc_clk = 1'b0;
    logic          noc_rst_n;
    logic          receive_valid;
    logic          receive_ready;
    logic [DW-1:0] receive_flit;
    logic          receive_is_header;
    logic          receive_is_tail;
    logic          sender_valid;
    logic          sender_ready;
    logic [DW-1:0] sender_flit;
    logic          sender_is_header;
    logic          sender_is_tail;
    logic [7:0]    receive_num;

    int total = 0;
    int bad   = 0;

    noc_test_node #(
        .X_ID(MY_X), .Y_ID(MY_Y), .DEST_X_ID(DX), .DEST_Y_ID(DY),
        .DATA_WIDTH(DW), .PKT_LEN(PKT_LEN), .NUM_PKTS(NUM_PKTS),
        .START_DELAY(START_DELAY), .GAP(GAP)
    ) dut (
        .noc_clk           (noc_clk),
        .noc_rst_n         (noc_rst_n),
        .receive_valid     (receive_valid),
        .receive_ready     (receive_ready),
        .receive_flit      (receive_flit),
        .receive_is_header (receive_is_header),
        .receive_is_tail   (receive_is_tail),
        .sender_valid      (sender_valid),
        .sender_ready      (sender_ready),
        .sender_flit       (sender_flit),
        .sender_is_header  (sender_is_header),
        .sender_is_tail    (sender_is_tail),
        .receive_num       (receive_num)
    );

    always #5 noc_clk = ~noc_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_flit(input int p, input int f);
        if (f == 0) return 32'((DX << 4) + DY + (MY_Y << 8) + (MY_X << 12) + (p << 16));
        return 32'((p << 16) + f);
    endfunction

    // Reference model: packet stream position, idle-cycle bookkeeping and
    // received-packet count, advanced from observed handshakes.
    int exp_pkt, exp_idx, idle_cnt, idle_req, exp_rx, tails_seen;
    bit sending, done, rx_match, prev_rst, armed;
    bit exp_valid;

    initial begin
        prev_rst = 1'b0;
        armed    = 1'b0;
        done     = 1'b0;
    end

    always @(negedge noc_clk) begin
        if (prev_rst) begin
            armed = 1'b1;
            chk("rst_valid", 32'(sender_valid), 0);
            chk("rst_flit", sender_flit, 0);
            chk("rst_hdr", 32'(sender_is_header), 0);
            chk("rst_tail", 32'(sender_is_tail), 0);
            chk("rst_rready", 32'(receive_ready), 0);
            chk("rst_rnum", 32'(receive_num), 0);
            exp_pkt = 0; exp_idx = 0; idle_cnt = 0; idle_req = START_DELAY;
            sending = 1'b0; done = 1'b0; exp_rx = 0; rx_match = 1'b0; tails_seen = 0;
        end else if (armed) begin
            exp_valid = !done && (sending || idle_cnt >= idle_req);
            chk("valid", 32'(sender_valid), 32'(exp_valid));
            if (exp_valid) begin
                sending = 1'b1;
                chk("flit", sender_flit, exp_flit(exp_pkt, exp_idx));
                chk("hdr", 32'(sender_is_header), 32'(exp_idx == 0));
                chk("tail", 32'(sender_is_tail), 32'(exp_idx == PKT_LEN - 1));
            end else begin
                chk("idle_hdr", 32'(sender_is_header), 0);
                chk("idle_tail", 32'(sender_is_tail), 0);
                idle_cnt++;
            end
            chk("rready", 32'(receive_ready), 1);
            chk("rnum", 32'(receive_num), 32'(exp_rx));
            if (sender_valid && sender_is_tail && sender_ready) tails_seen++;
            // advance for the coming edge
            if (exp_valid && sender_ready) begin
                if (exp_idx == PKT_LEN - 1) begin
                    exp_idx = 0; exp_pkt++; sending = 1'b0; idle_cnt = 0; idle_req = GAP;
                    if (exp_pkt == NUM_PKTS) done = 1'b1;
                end else begin
                    exp_idx++;
                end
            end
            if (receive_valid) begin
                if (receive_is_header)
                    rx_match = (((receive_flit >> 4) & 32'hF) == MY_X) && ((receive_flit & 32'hF) == MY_Y);
                if (receive_is_tail && rx_match && exp_rx < 255) exp_rx++;
            end
        end
        prev_rst = noc_rst_n;
    end

    task automatic send_pkt(input int dx, input int dy, input int len);
        for (int i = 0; i < len; i++) begin
            receive_valid     = 1'b1;
            receive_is_header = (i == 0);
            receive_is_tail   = (i == len - 1);
            receive_flit      = (i == 0) ? 32'((dx << 4) + dy + (1 << 12) + (1 << 8)) : 32'(i);
            @(posedge noc_clk); #1;
        end
        receive_valid = 1'b0; receive_is_header = 1'b0; receive_is_tail = 1'b0; receive_flit = '0;
    endtask

    // Release reset and return the cycle on which the first header appears
    task automatic release_and_time(output int cyc);
        noc_rst_n = 1'b0;
        cyc = 0;
        while (!sender_valid && cyc < 20) begin
            @(posedge noc_clk); #1;
            cyc++;
        end
    endtask

    int  cyc;
    logic [31:0] hold;

    initial begin
        noc_rst_n = 1'b1; sender_ready = 1'b1;
        receive_valid = 1'b0; receive_flit = '0; receive_is_header = 1'b0; receive_is_tail = 1'b0;
        repeat (3) @(posedge noc_clk);
        #1;
        release_and_time(cyc);
        chk("first_hdr_cycle", 32'(cyc), 5);
        chk("first_hdr_flit", sender_flit, 32'h0000_0011);
        chk("first_hdr_flag", 32'(sender_is_header), 1);

        for (int c = 0; c < 10 && !sender_is_tail; c++) begin @(posedge noc_clk); #1; end
        chk("first_tail_flag", 32'(sender_is_tail), 1);
        chk("first_tail_flit", sender_flit, 32'h0000_0003);

        // backpressure in the middle of packet 1
        for (int c = 0; c < 40 && !(sender_valid && sender_flit == 32'h0001_0001); c++) begin
            @(posedge noc_clk); #1;
        end
        chk("bp_reached", sender_flit, 32'h0001_0001);
        sender_ready = 1'b0;
        hold = sender_flit;
        repeat (3) begin
            @(posedge noc_clk); #1;
            chk("bp_hold_flit", sender_flit, hold);
            chk("bp_hold_valid", 32'(sender_valid), 1);
        end
        sender_ready = 1'b1;
        @(posedge noc_clk); #1;
        chk("bp_next_flit", sender_flit, 32'h0001_0002);

        // receive matching
        send_pkt(0, 0, 4);
        chk("rx_match_cnt", 32'(receive_num), 1);
        send_pkt(1, 0, 4);
        chk("rx_nomatch_cnt", 32'(receive_num), 1);
        send_pkt(0, 0, 1);
        chk("rx_single_cnt", 32'(receive_num), 2);
        for (int i = 0; i < 260; i++) send_pkt(0, 0, 1);
        chk("rx_saturate", 32'(receive_num), 255);

        // drain the sender
        for (int c = 0; c < 600 && !done; c++) begin @(posedge noc_clk); #1; end
        chk("tx_done_valid", 32'(sender_valid), 0);
        chk("tx_tails", 32'(tails_seen), NUM_PKTS);
        repeat (20) @(posedge noc_clk);
        #1;
        chk("tx_done_stays", 32'(sender_valid), 0);

        // restart, then reset in the middle of a packet
        noc_rst_n = 1'b1;
        @(posedge noc_clk); #1;
        release_and_time(cyc);
        send_pkt(0, 0, 1);
        for (int c = 0; c < 10 && !(sender_valid && sender_flit[7:0] == 8'd2); c++) begin
            @(posedge noc_clk); #1;
        end
        chk("mid_reached", sender_flit, 32'h0000_0002);
        noc_rst_n = 1'b1;
        @(posedge noc_clk); #1;
        chk("mid_rst_valid", 32'(sender_valid), 0);
        chk("mid_rst_flit", sender_flit, 0);
        chk("mid_rst_flags", 32'({sender_is_header, sender_is_tail}), 0);
        chk("mid_rst_rready", 32'(receive_ready), 0);
        chk("mid_rst_rnum", 32'(receive_num), 0);
        release_and_time(cyc);
        chk("restart_hdr_cycle", 32'(cyc), 5);
        chk("restart_hdr_flit", sender_flit, 32'h0000_0011);
        repeat (30) @(posedge noc_clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
